// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle RISC-V datapath.
// Emits per-cycle enables/selects for the shared ALU and unified memory.
module multicycle_control_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_SUB  = 2'd1,
      ALU_FUNC = 2'd2
   } alu_op_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t     state;
   state_t     state_next;
   alu_op_t    alu_op;
   logic       pc_update;
   logic       branch;
   logic       done;
   logic       illegal;
   logic       adr;
   logic       mem_we;
   logic       ir_we;
   logic       reg_we;
   logic [1:0] res_sel;
   logic [1:0] a_sel;
   logic [1:0] b_sel;
   logic [2:0] func_ctl;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= state_t'(RESET_STATE);
      else        state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      alu_op     = ALU_ADD;
      pc_update  = 1'b0;
      branch     = 1'b0;
      done       = 1'b0;
      illegal    = 1'b0;
      adr        = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      res_sel    = 2'b00;
      a_sel      = 2'b00;
      b_sel      = 2'b00;
      case (state)
         FETCH: begin
            state_next = DECODE;
            ir_we      = 1'b1;
            b_sel      = 2'b10;
            res_sel    = 2'b10;
            pc_update  = 1'b1;
         end
         DECODE: begin
            a_sel = 2'b01;
            b_sel = 2'b01;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECR;
               OP_I:         state_next = EXECI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default: begin
                  state_next = FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            a_sel      = 2'b10;
            b_sel      = 2'b01;
         end
         MEMREAD: begin
            state_next = MEMWB;
            adr        = 1'b1;
         end
         MEMWB: begin
            res_sel = 2'b01;
            reg_we  = 1'b1;
            done    = 1'b1;
         end
         MEMWRITE: begin
            adr    = 1'b1;
            mem_we = 1'b1;
            done   = 1'b1;
         end
         EXECR: begin
            state_next = ALUWB;
            a_sel      = 2'b10;
            alu_op     = ALU_FUNC;
         end
         EXECI: begin
            state_next = ALUWB;
            a_sel      = 2'b10;
            b_sel      = 2'b01;
            alu_op     = ALU_FUNC;
         end
         ALUWB: begin
            reg_we = 1'b1;
            done   = 1'b1;
         end
         BEQ: begin
            a_sel  = 2'b10;
            alu_op = ALU_SUB;
            branch = 1'b1;
            done   = 1'b1;
         end
         JAL: begin
            state_next = ALUWB;
            a_sel      = 2'b01;
            b_sel      = 2'b10;
            pc_update  = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   // funct7 only selects sub for R-type; addi ignores instr[30]
   always_comb begin
      func_ctl = 3'b000;
      case (funct3)
         3'b000:  func_ctl = (op[5] & funct7) ? 3'b001 : 3'b000;
         3'b010:  func_ctl = 3'b101;
         3'b110:  func_ctl = 3'b011;
         3'b111:  func_ctl = 3'b010;
         default: func_ctl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Reset forces enables low and selects to their FETCH values
   always_comb begin
      state_dbg = state;
      if (!rst_n) begin
         PCWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         ResultSrc  = 2'b10;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b10;
         RegWrite   = 1'b0;
         ALUControl = 3'b000;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end else begin
         PCWrite    = pc_update | (branch & Zero);
         AdrSrc     = adr;
         MemWrite   = mem_we;
         IRWrite    = ir_we;
         ResultSrc  = res_sel;
         ALUSrcA    = a_sel;
         ALUSrcB    = b_sel;
         RegWrite   = reg_we;
         instr_done = done;
         illegal_op = illegal;
         case (alu_op)
            ALU_SUB:  ALUControl = 3'b001;
            ALU_FUNC: ALUControl = func_ctl;
            default:  ALUControl = 3'b000;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm.
// Expected outputs come from per-instruction state lists and per-state rules.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic       instr_done, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_dbg;

   int errors = 0;
   int checks = 0;
   int seq[$];

   multicycle_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
      .funct7(funct7), .Zero(Zero), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .instr_done(instr_done), .illegal_op(illegal_op),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   logic [21:0] obs;
   assign obs = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ImmSrc,
                 ALUControl, instr_done, illegal_op};

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   function automatic bit legal(logic [6:0] o);
      return o inside {LW, SW, RT, IT, BR, JL};
   endfunction

   function automatic logic [2:0] fn_ctl(logic [6:0] o, logic [2:0] f3, logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'd1 : 3'd0;
         3'b010:  return 3'd5;
         3'b110:  return 3'd3;
         3'b111:  return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [21:0] exp_vec(int s, bit rst, logic [6:0] o,
                                           logic [2:0] f3, logic f7, logic z);
      logic pcw, adr, mw, irw, rw, dn, il;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      pcw = (s == 0) || (s == 10) || (s == 9 && z);
      adr = (s == 3) || (s == 5);
      mw  = (s == 5);
      irw = (s == 0);
      rs  = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
      sa  = (s == 1 || s == 10) ? 2'd1 :
            (s inside {2, 6, 7, 9}) ? 2'd2 : 2'd0;
      sb  = (s == 0 || s == 10) ? 2'd2 :
            (s inside {1, 2, 7}) ? 2'd1 : 2'd0;
      rw  = (s == 4) || (s == 8);
      imm = (o == SW) ? 2'd1 : (o == BR) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
      alu = (s == 9) ? 3'd1 : (s == 6 || s == 7) ? fn_ctl(o, f3, f7) : 3'd0;
      dn  = s inside {4, 5, 8, 9};
      il  = (s == 1) && !legal(o);
      if (rst) begin
         {pcw, adr, mw, irw, rw, dn, il} = '0;
         rs = 2'd2; sa = 2'd0; sb = 2'd2; alu = 3'd0;
      end
      return {4'(s), pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, dn, il};
   endfunction

   task automatic apply(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
      op = o; funct3 = f3; funct7 = f7; Zero = z;
      case (o)
         LW:      seq = '{0, 1, 2, 3, 4};
         SW:      seq = '{0, 1, 2, 5};
         RT:      seq = '{0, 1, 6, 8};
         IT:      seq = '{0, 1, 7, 8};
         BR:      seq = '{0, 1, 9};
         JL:      seq = '{0, 1, 10, 8};
         default: seq = '{0, 1};
      endcase
   endtask

   task automatic test_reset();
      logic [21:0] e;
      rst_n = 1'b0;
      op = LW; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         e = exp_vec(0, 1, op, funct3, funct7, Zero);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset: got %h exp %h", obs, e);
         end
      end
      rst_n = 1'b1; #1;
      e = exp_vec(0, 0, op, funct3, funct7, Zero);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_release: got %h exp %h", obs, e);
      end
   endtask

   task automatic test_instr(input string nm, input logic [6:0] o,
                             input logic [2:0] f3, input logic f7,
                             input logic z);
      logic [21:0] e;
      int done_cnt;
      apply(o, f3, f7, z);
      done_cnt = 0;
      foreach (seq[i]) begin
         #1;
         e = exp_vec(seq[i], 0, o, f3, f7, z);
         done_cnt += int'(instr_done);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s cyc%0d: got %h exp %h", nm, i, obs, e);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (state_dbg !== 4'd0 || done_cnt !== int'(legal(o))) begin
         errors++;
         $display("FAIL %s end: state %0d done %0d exp 0/%0d",
                  nm, state_dbg, done_cnt, int'(legal(o)));
      end
   endtask

   task automatic test_reset_mid();
      logic [21:0] e;
      apply(LW, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         e = exp_vec(seq[i], 0, LW, 3'd0, 1'b0, 1'b0);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rst_mid cyc%0d: got %h exp %h", i, obs, e);
         end
         @(negedge clk);
      end
      rst_n = 1'b0; #1;
      e = exp_vec(3, 1, LW, 3'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL rst_mid memread: got %h exp %h", obs, e);
      end
      @(negedge clk); #1;
      e = exp_vec(0, 1, LW, 3'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL rst_mid held: got %h exp %h", obs, e);
      end
      rst_n = 1'b1; #1;
      e = exp_vec(0, 0, LW, 3'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL rst_mid fetch: got %h exp %h", obs, e);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [7] = '{LW, SW, RT, IT, BR, JL, 7'b0};
      logic [6:0] o;
      logic [21:0] e;
      for (int n = 0; n < 60; n++) begin
         o = ops[$urandom_range(0, 6)];
         if (n % 7 == 6) o = 7'($urandom);
         apply(o, 3'($urandom), 1'($urandom), 1'($urandom));
         foreach (seq[i]) begin
            #1;
            e = exp_vec(seq[i], 0, op, funct3, funct7, Zero);
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL rand%0d op=%b cyc%0d: got %h exp %h",
                        n, op, i, obs, e);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_instr("lw", LW, 3'b010, 1'b0, 1'b0);
      test_instr("sw", SW, 3'b010, 1'b0, 1'b1);
      test_instr("sub", RT, 3'b000, 1'b1, 1'b0);
      test_instr("addi", IT, 3'b000, 1'b1, 1'b0);
      test_instr("slt", RT, 3'b010, 1'b0, 1'b0);
      test_instr("or", IT, 3'b110, 1'b0, 1'b0);
      test_instr("and", RT, 3'b111, 1'b0, 1'b0);
      test_instr("beq_taken", BR, 3'b000, 1'b0, 1'b1);
      test_instr("beq_not", BR, 3'b000, 1'b0, 1'b0);
      test_instr("jal", JL, 3'b000, 1'b0, 1'b0);
      test_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
